bus_invert_rx: RTL and testbench
================================

# bus_invert_rx

Receive-side decoder for the 8-bit bus-invert coded link inside the MIPS datapath test fabric. The transmit end sends either the raw byte or its bitwise complement, plus an invert flag, to cut line toggles. This block restores the original byte and buffers it in a 2-entry skid FIFO with valid/ready flow control. It also checks the bus-invert guarantee (at most 4 data-line toggles per beat) and counts inverted beats for power statistics.

## Interface
Parameters:
- DATA_W, 8, data lane width; only 8 is supported.
- CNT_W, 16, width of the inverted-beat counter.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, a line beat is presented.
- in_data, input, 8, encoded line byte.
- in_inv, input, 1, 1 = in_data is the complement of the payload.
- in_ready, output, 1, block can accept a beat this cycle.
- out_valid, output, 1, a decoded byte is available.
- out_data, output, 8, decoded payload byte.
- out_ready, input, 1, consumer accepts out_data this cycle.
- flip_count, output, CNT_W, number of accepted beats with in_inv=1; saturating.
- coding_err, output, 1, sticky flag for a toggle-limit violation.

## Operation
- Accept: a beat is accepted when in_valid & in_ready at the clock edge.
- Decode: decoded = in_inv ? ~in_data : in_data. The decoded byte is pushed into the FIFO on accept.
- FIFO: 2 entries, in order. in_ready = (count < 2). out_valid = (count > 0). out_data = head entry.
- Pop: a pop happens on out_valid & out_ready.
- Simultaneous push and pop at count=1: count stays 1, and the new byte becomes the head on the next cycle.
- Push and pop together at count=2 cannot occur, because in_ready=0 at count=2.
- Toggle check: prev_line (8 bits) holds the in_data of the last accepted beat.
  - On accept, compute popcount(in_data ^ prev_line).
  - If the result is > 4, coding_err sets to 1 and stays set until rst.
  - The beat is still decoded and delivered.
  - prev_line updates to in_data on every accept and only on accept.
- flip_count increments on each accept with in_inv=1. It holds at all-ones and does not wrap.
- Reset values: count=0, in_ready=1, out_valid=0, out_data=8'h00 (empty entries read as 0), prev_line=8'h00, flip_count=0, coding_err=0.

## Timing
- Latency: a byte accepted at edge N is on out_data with out_valid=1 after edge N, whenever the FIFO was empty before N. Zero-cycle pass-through is not allowed.
- in_ready is registered-state derived (a function of count only). It never depends combinationally on out_ready.
- coding_err and flip_count reflect a beat accepted at edge N after edge N.
- Reset mid-operation: rst at edge N discards all FIFO contents, counters and flags, regardless of in_valid or out_ready in that cycle. No beat is accepted in a reset cycle.
- out_data is stable while out_valid=1 and out_ready=0.

## Structure
- Shared package constants: BI_DATA_W=8, BI_MAX_TOGGLES=4. The encoder and decoder reuse both.
- Sub-module bi_skid_fifo2: a 2-entry, 8-bit FIFO with push/pop/count.
- The decode logic, popcount check, counter and error flag sit in bus_invert_rx.
- The popcount is a combinational function local to the block.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_data=8'h00, flip_count=0, coding_err=0.
- Inverted beat:
  - Stimulus: in_data=8'h0F, in_inv=1, out_ready=1 (distance from 00 is 4).
  - Response: next cycle out_data=8'hF0, flip_count=1, coding_err=0.
- Backpressure:
  - Stimulus: out_ready=0, offer beats 8'h01, 8'h03, 8'h07 (inv=0).
  - Response: the first two are accepted; in_ready=0 and the third is held. After out_ready=1, bytes come out in order 01, 03, 07.
- Violation:
  - Stimulus: after reset, send in_data=8'hFF, in_inv=0.
  - Response: out_data=8'hFF is delivered and coding_err=1. coding_err stays 1 through 10 further legal beats.
- Saturation:
  - Stimulus: CNT_W=4, send 20 beats with in_inv=1, payload alternating 00/0F encodings.
  - Response: flip_count stops at 4'hF.
- Mid-operation reset:
  - Stimulus: FIFO holds 2 entries and flip_count=3; assert rst for 1 cycle with in_valid=1.
  - Response: all outputs return to reset values, no beat is accepted, and the next accepted beat decodes normally.

Source files
------------

// File: rtl/bus_invert_rx_pkg.sv
// Shared constants and types for the bus-invert coded byte link.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   BI_DATA_W      - width of the coded data lane
//   BI_MAX_TOGGLES - most data-line toggles a legal beat may cause
//   BI_TOG_W       - width needed to hold a toggle count of 0..BI_DATA_W
//   bi_byte_t      - one data-lane word
package bus_invert_rx_pkg;

  localparam int BI_DATA_W      = 8;
  localparam int BI_MAX_TOGGLES = 4;
  localparam int BI_TOG_W       = $clog2(BI_DATA_W + 1);

  typedef logic [BI_DATA_W-1:0] bi_byte_t;

endpackage

// File: rtl/bus_invert_rx_if.sv
// Line-side and consumer-side handshake bundle of the bus-invert receiver.
// Latency: n/a (wires only).
// Backpressure: in_ready from receiver to line, out_ready from consumer to receiver.
//
// Signals:
//   in_valid/in_data/in_inv/in_ready  - coded beat from the line, valid/ready
//   out_valid/out_data/out_ready      - decoded byte to the consumer, valid/ready
// Modports:
//   master - drives the line beat and the consumer ready (environment side)
//   slave  - the receiver itself
interface bus_invert_rx_if
  import bus_invert_rx_pkg::*;
#(
  parameter int DATA_W = BI_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_inv;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_inv,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_inv,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/bus_invert_rx_skid_fifo2.sv
// Two-entry in-order FIFO used as the skid buffer behind the decoder.
// Latency: a pushed word is visible on dout after the push edge (no pass-through).
// Backpressure: push ignored when count==2, pop ignored when count==0.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write din at the tail
//   pop        - drop the head entry
//   dout       - head entry, reads 0 while empty
//   count      - occupancy 0..2
module bi_skid_fifo2
  import bus_invert_rx_pkg::*;
#(
  parameter int W = BI_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // Guard against misuse so occupancy can never leave 0..2.
  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop  && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave occupancy unchanged; at count=1 the
      // read pointer then lands on the slot just written.
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Stale slots are hidden so an empty FIFO always reads as zero.
  assign dout = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_invert_rx.sv
// Bus-invert link receiver: restores the payload byte, buffers it in a 2-entry skid FIFO,
// Latency: byte accepted at edge N is on out_data after edge N when the FIFO was empty.
// Backpressure: in_ready = FIFO not full (state only, never combinational on out_ready).
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   bus         - slave side of bus_invert_rx_if (line beat in, decoded byte out)
//   flip_count  - saturating count of accepted beats sent inverted
//   coding_err  - sticky: some accepted beat toggled more than BI_MAX_TOGGLES lines
module bus_invert_rx
  import bus_invert_rx_pkg::*;
#(
  parameter int DATA_W = BI_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  bus_invert_rx_if.slave   bus,
  output logic [CNT_W-1:0] flip_count,
  output logic             coding_err
);

  function automatic logic [BI_TOG_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [BI_TOG_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + BI_TOG_W'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]          fifo_count;
  logic [DATA_W-1:0]   fifo_dout;
  logic [DATA_W-1:0]   decoded;
  logic [DATA_W-1:0]   prev_line;
  logic [BI_TOG_W-1:0] toggles;
  logic                accept;
  logic                pop;
  logic                too_many;

  assign bus.in_ready  = (fifo_count != 2'd2);
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = fifo_dout;

  // No beat is taken in a reset cycle even if the line is offering one.
  assign accept = bus.in_valid && bus.in_ready && !rst;
  assign pop    = bus.out_valid && bus.out_ready;

  assign decoded  = bus.in_inv ? ~bus.in_data : bus.in_data;

  // Toggle distance is measured on the raw line values, not the payload,
  // since that is what the transmitter's invert decision bounds.
  assign toggles  = popcount(bus.in_data ^ prev_line);
  assign too_many = (toggles > BI_TOG_W'(BI_MAX_TOGGLES));

  bi_skid_fifo2 #(
    .W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (decoded),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line  <= '0;
      flip_count <= '0;
      coding_err <= 1'b0;
    end else if (accept) begin
      prev_line <= bus.in_data;
      if (too_many) begin
        coding_err <= 1'b1;
      end
      // Hold at all-ones rather than wrap so a long run still reads as "many".
      if (bus.in_inv && (flip_count != {CNT_W{1'b1}})) begin
        flip_count <= flip_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_invert_rx.sv
module tb_bus_invert_rx;
  import bus_invert_rx_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_inv;
  logic       out_ready;

  // Two receivers share one stimulus: default counter width and a 4-bit
  // counter that reaches saturation quickly.
  bus_invert_rx_if #(.DATA_W(8)) bif ();
  bus_invert_rx_if #(.DATA_W(8)) sif ();

  assign bif.in_valid  = in_valid;
  assign bif.in_data   = in_data;
  assign bif.in_inv    = in_inv;
  assign bif.out_ready = out_ready;
  assign sif.in_valid  = in_valid;
  assign sif.in_data   = in_data;
  assign sif.in_inv    = in_inv;
  assign sif.out_ready = out_ready;

  logic [15:0] flip16;
  logic [3:0]  flip4;
  logic        err16;
  logic        err4;

  bus_invert_rx #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .flip_count (flip16),
    .coding_err (err16)
  );

  bus_invert_rx #(.DATA_W(8), .CNT_W(4)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .bus        (sif),
    .flip_count (flip4),
    .coding_err (err4)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: payload queue, last line value, flip total, sticky error.
  logic [7:0] mq[$];
  logic [7:0] m_prev;
  int         m_flips;
  bit         m_err;
  bit         last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter rule: send the complement whenever raw would toggle too many lines.
  task automatic encode(input logic [7:0] raw, output logic [7:0] line, output logic inv);
    if ($countones(raw ^ m_prev) > BI_MAX_TOGGLES) begin
      line = ~raw;
      inv  = 1'b1;
    end else begin
      line = raw;
      inv  = 1'b0;
    end
  endtask

  // One clock: predict from pre-edge model state, advance, compare after the edge.
  task automatic cycle();
    bit acc;
    bit pp;
    acc = !rst && in_valid && (mq.size() < 2);
    pp  = !rst && out_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_prev  = 8'h00;
      m_flips = 0;
      m_err   = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(in_inv ? ~in_data : in_data);
        if ($countones(in_data ^ m_prev) > BI_MAX_TOGGLES) m_err = 1'b1;
        m_prev = in_data;
        if (in_inv) m_flips++;
      end
    end
    last_acc = acc;
    chk("in_ready",      32'(bif.in_ready),  32'(mq.size() < 2));
    chk("out_valid",     32'(bif.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 32'(bif.out_data), 32'(mq[0]));
    chk("flip_count",    32'(flip16),        32'((m_flips > 65535) ? 65535 : m_flips));
    chk("coding_err",    32'(err16),         32'(m_err));
    chk("sat_in_ready",  32'(sif.in_ready),  32'(mq.size() < 2));
    if (mq.size() > 0) chk("sat_out_data", 32'(sif.out_data), 32'(mq[0]));
    chk("sat_flip_count", 32'(flip4),        32'((m_flips > 15) ? 15 : m_flips));
    chk("sat_coding_err", 32'(err4),         32'(m_err));
  endtask

  // Offer one beat and hold it until the model says it was taken (bounded).
  task automatic send(input logic [7:0] d, input logic inv);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ln;
    logic       iv;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_inv = 1'b0; out_ready = 1'b0;
    m_prev = 8'h00; m_flips = 0; m_err = 1'b0; last_acc = 1'b0;

    // Reset then idle.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_out_data",   32'(bif.out_data),  32'h00);
    chk("rst_in_ready",   32'(bif.in_ready),  32'h1);
    chk("rst_out_valid",  32'(bif.out_valid), 32'h0);

    // Inverted beat, distance 4 from the reset line value.
    out_ready = 1'b1;
    send(8'h0F, 1'b1);
    chk("inv_out_data",   32'(bif.out_data),  32'hF0);
    chk("inv_flip_count", 32'(flip16),        32'h1);
    chk("inv_coding_err", 32'(err16),         32'h0);
    cycle();

    // Backpressure: two taken, third held until the consumer drains.
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    in_valid = 1'b1; in_data = 8'h07; in_inv = 1'b0;
    cycle();
    cycle();
    chk("bp_held_in_ready", 32'(bif.in_ready), 32'h0);
    chk("bp_head",          32'(bif.out_data), 32'h01);
    out_ready = 1'b1;
    send(8'h07, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    chk("bp_drained", 32'(bif.out_valid), 32'h0);

    // Violation: FF after reset toggles all 8 lines.
    do_reset();
    send(8'hFF, 1'b0);
    chk("viol_out_data", 32'(bif.out_data), 32'hFF);
    chk("viol_err",      32'(err16),        32'h1);
    for (int i = 0; i < 10; i++) begin
      encode(8'($urandom), ln, iv);
      send(ln, iv);
    end
    chk("viol_sticky", 32'(err16), 32'h1);

    // Saturation: 20 inverted beats alternating 00/0F on the line.
    do_reset();
    for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 8'h00 : 8'h0F, 1'b1);
    chk("sat_stop",  32'(flip4),  32'hF);
    chk("sat_wide",  32'(flip16), 32'd20);
    chk("sat_noerr", 32'(err4),   32'h0);

    // Mid-operation reset with the FIFO full and flip_count=3.
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h00, 1'b1);
    cycle();
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    chk("pre_rst_full", 32'(bif.in_ready), 32'h0);
    chk("pre_rst_flip", 32'(flip16),       32'h3);
    in_valid = 1'b1; in_data = 8'hFF; in_inv = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_data", 32'(bif.out_data),  32'h00);
    chk("mid_rst_valid",    32'(bif.out_valid), 32'h0);
    chk("mid_rst_flip",     32'(flip16),        32'h0);
    send(8'h3C, 1'b1);
    chk("post_rst_data", 32'(bif.out_data), 32'hC3);
    chk("post_rst_err",  32'(err16),        32'h0);

    // Random legal traffic with random consumer stalls.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      encode(8'($urandom), ln, iv);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ln;
      in_inv    = iv;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    chk("rand_legal_noerr", 32'(err16), 32'h0);

    // Random unencoded traffic; the model decides when the error should fire.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      in_data   = 8'($urandom);
      in_inv    = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
